// File: rtl/register_bank_writer_if.sv
// rtl/register_bank_writer_if.sv - write-back port and flattened readout of the general-purpose register bank
interface register_bank_writer_if #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5
);
    logic                            rf_le;
    logic [ADDR_W-1:0]               rw;
    logic [DATA_W-1:0]               pw;
    logic [(1<<ADDR_W)-1:0]          le_oh;
    logic [DATA_W*(1<<ADDR_W)-1:0]   q_all;
    logic                            wr_done;
    logic [ADDR_W-1:0]               last_rw;
    logic [15:0]                     wr_count;

    modport master (
        output rf_le, rw, pw,
        input  le_oh, q_all, wr_done, last_rw, wr_count
    );

    modport slave (
        input  rf_le, rw, pw,
        output le_oh, q_all, wr_done, last_rw, wr_count
    );
endinterface

// File: rtl/register_bank_writer.sv
// rtl/register_bank_writer.sv - one-hot decoded write side of the 32-entry register file with R0 hardwired to zero
module register_bank_writer #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5
) (
    input  logic                  clk,
    input  logic                  reset,
    register_bank_writer_if.slave bus
);
    localparam int NREG = 1 << ADDR_W;

    logic [DATA_W-1:0] regs [1:NREG-1];
    logic              commit;

    // Bit 0 is never set, so a write to R0 is dropped before it reaches storage
    always_comb begin
        bus.le_oh = '0;
        for (int k = 1; k < NREG; k++) begin
            bus.le_oh[k] = bus.rf_le && (bus.rw == ADDR_W'(k));
        end
    end

    assign commit = |bus.le_oh;

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int k = 1; k < NREG; k++) begin
                regs[k] <= '0;
            end
            bus.wr_done  <= 1'b0;
            bus.last_rw  <= '0;
            bus.wr_count <= '0;
        end else begin
            for (int k = 1; k < NREG; k++) begin
                if (bus.le_oh[k]) begin
                    regs[k] <= bus.pw;
                end
            end
            bus.wr_done <= commit;
            if (commit) begin
                bus.last_rw  <= bus.rw;
                bus.wr_count <= bus.wr_count + 16'd1;
            end
        end
    end

    assign bus.q_all[DATA_W-1:0] = '0;

    for (genvar g = 1; g < NREG; g++) begin : g_readout
        assign bus.q_all[g*DATA_W +: DATA_W] = regs[g];
    end
endmodule
